// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and its surroundings.
// Optional feature macro: PLL_LOSS_CNT_EN adds the 8-bit loss_cnt signal.
interface pll_lock_supervisor_if;
  logic       pll_locked;
  logic       ce_main;
  logic       ce_shift;
  logic       core_rst;
  logic       ready;
`ifdef PLL_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  // Supervisor side: consumes the lock flag, produces enables and reset.
  modport master (
    input  pll_locked,
    output ce_main,
    output ce_shift,
    output core_rst,
    output ready
`ifdef PLL_LOSS_CNT_EN
    , output loss_cnt
`endif
  );

  // PLL wrapper / core side.
  modport slave (
    output pll_locked,
    input  ce_main,
    input  ce_shift,
    input  core_rst,
    input  ready
`ifdef PLL_LOSS_CNT_EN
    , input  loss_cnt
`endif
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: synchronizes the PLL lock flag, waits for stable lock,
// runs the clock-enable divider for a reset-extension window and releases
// core_rst on a divider boundary. Loss of lock re-asserts reset at once.
// Optional feature macro: PLL_LOSS_CNT_EN adds a saturating lock-loss counter.
module pll_lock_supervisor #(
  parameter int unsigned LOCK_HOLD = 4096,
  parameter int unsigned DIV       = 8,
  parameter int unsigned PHASE_OFS = 2,
  parameter int unsigned RST_EXTRA = 16
) (
  input logic                   clk_sys,
  input logic                   rst,
  pll_lock_supervisor_if.master bus
);

  localparam int unsigned HoldW  = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;
  localparam int unsigned DivW   = $clog2(DIV);
  localparam int unsigned ExtraW = (RST_EXTRA > 1) ? $clog2(RST_EXTRA) : 1;

  localparam logic [HoldW-1:0]  HoldMax  = HoldW'(LOCK_HOLD - 1);
  localparam logic [DivW-1:0]   DivMax   = DivW'(DIV - 1);
  localparam logic [DivW-1:0]   PhaseOfs = DivW'(PHASE_OFS);
  localparam logic [ExtraW-1:0] ExtraMax = ExtraW'(RST_EXTRA - 1);

  typedef enum logic [1:0] {
    StWaitLock,
    StHold,
    StAlign,
    StRun
  } state_e;

  logic              lock_meta_q;
  logic              lock_s;
  state_e            state_q, state_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [ExtraW-1:0] extra_q, extra_d;

  // Two-flop synchronizer; lock_s is the only consumer of pll_locked.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      lock_meta_q <= 1'b0;
      lock_s      <= 1'b0;
    end else begin
      lock_meta_q <= bus.pll_locked;
      lock_s      <= lock_meta_q;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q <= StWaitLock;
      hold_q  <= '0;
      div_q   <= '0;
      extra_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      div_q   <= div_d;
      extra_q <= extra_d;
    end
  end

  // Next-state and counter logic; loss of lock overrides every other transition.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    div_d   = div_q;
    extra_d = extra_q;
    if (!lock_s) begin
      state_d = StWaitLock;
      hold_d  = '0;
      div_d   = '0;
      extra_d = '0;
    end else begin
      case (state_q)
        StWaitLock: begin
          hold_d  = '0;
          div_d   = '0;
          extra_d = '0;
          state_d = StHold;
        end
        StHold: begin
          if (hold_q == HoldMax) begin
            state_d = StAlign;
          end else begin
            hold_d = hold_q + HoldW'(1);
          end
        end
        StAlign: begin
          div_d   = (div_q == DivMax) ? '0 : div_q + DivW'(1);
          extra_d = (extra_q == ExtraMax) ? extra_q : extra_q + ExtraW'(1);
          // Leave on the last divider phase so RUN starts with div = 0.
          if (extra_q == ExtraMax && div_q == DivMax) begin
            state_d = StRun;
          end
        end
        StRun: begin
          div_d = (div_q == DivMax) ? '0 : div_q + DivW'(1);
        end
        default: state_d = StWaitLock;
      endcase
    end
  end

  // Outputs decoded from registered state only, so core_rst cannot glitch.
  always_comb begin
    bus.core_rst = (state_q != StRun);
    bus.ready    = (state_q == StRun);
    bus.ce_main  = ((state_q == StAlign) || (state_q == StRun)) && (div_q == '0);
    bus.ce_shift = ((state_q == StAlign) || (state_q == StRun)) && (div_q == PhaseOfs);
  end

`ifdef PLL_LOSS_CNT_EN
  logic [7:0] loss_q;

  // Count RUN -> WAIT_LOCK transitions, saturating at 255.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      loss_q <= 8'd0;
    end else if (state_q == StRun && !lock_s && loss_q != 8'hff) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign bus.loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor (LOCK_HOLD=16, DIV=8, PHASE_OFS=2,
// RST_EXTRA=5). Inputs change and outputs are sampled on the falling edge.
module tb_pll_lock_supervisor;

  localparam int AlignAt = 18;  // lock sampled at edge N -> ALIGN after N+2+16
  localparam int RunAt   = 26;  // ALIGN + 8 cycles: extra=4 and div=7 coincide
  localparam int Div     = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   exp_loss = 0;
  logic any_act;

  pll_lock_supervisor_if bus ();

  pll_lock_supervisor #(
    .LOCK_HOLD(16),
    .DIV      (8),
    .PHASE_OFS(2),
    .RST_EXTRA(5)
  ) dut (
    .clk_sys(clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_loss(input string tag);
`ifdef PLL_LOSS_CNT_EN
    check_byte(tag, bus.loss_cnt, 8'(exp_loss));
`else
    if (exp_loss < 0) $display("%s", tag);
`endif
  endtask

  task automatic check_reset_values(input string tag);
    check_bit({tag, ".core_rst"}, bus.core_rst, 1'b1);
    check_bit({tag, ".ready"}, bus.ready, 1'b0);
    check_bit({tag, ".ce_main"}, bus.ce_main, 1'b0);
    check_bit({tag, ".ce_shift"}, bus.ce_shift, 1'b0);
    check_loss({tag, ".loss_cnt"});
  endtask

  // Called on a falling edge with the FSM in WAIT_LOCK and both sync flops 0.
  // k counts rising edges from the one that first samples pll_locked high.
  task automatic run_release(input string tag, input int n);
    logic exp_rst, exp_main, exp_shift;
    bus.pll_locked = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      exp_rst   = (k < RunAt);
      exp_main  = (k >= AlignAt) && (((k - AlignAt) % Div) == 0);
      exp_shift = (k >= AlignAt) && (((k - AlignAt) % Div) == 2);
      check_bit({tag, ".core_rst"}, bus.core_rst, exp_rst);
      check_bit({tag, ".ready"}, bus.ready, ~exp_rst);
      check_bit({tag, ".ce_main"}, bus.ce_main, exp_main);
      check_bit({tag, ".ce_shift"}, bus.ce_shift, exp_shift);
    end
  endtask

  // Called on a falling edge while in RUN; leaves the FSM in WAIT_LOCK.
  task automatic drop_in_run(input string tag);
    bus.pll_locked = 1'b0;
    @(negedge clk);
    check_bit({tag, ".still_run0"}, bus.core_rst, 1'b0);
    @(negedge clk);
    check_bit({tag, ".still_run1"}, bus.core_rst, 1'b0);
    @(negedge clk);
    exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
    check_bit({tag, ".core_rst"}, bus.core_rst, 1'b1);
    check_bit({tag, ".ready"}, bus.ready, 1'b0);
    check_bit({tag, ".ce_main"}, bus.ce_main, 1'b0);
    check_bit({tag, ".ce_shift"}, bus.ce_shift, 1'b0);
    check_loss({tag, ".loss_cnt"});
    @(negedge clk);
    check_bit({tag, ".ce_main_late"}, bus.ce_main, 1'b0);
    check_bit({tag, ".core_rst_late"}, bus.core_rst, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("por");

    // 100 idle cycles without lock.
    rst = 1'b0;
    any_act = 1'b0;
    repeat (100) begin
      @(negedge clk);
      any_act = any_act | bus.ce_main | bus.ce_shift | bus.ready | ~bus.core_rst;
    end
    check_bit("idle.activity", any_act, 1'b0);
    check_reset_values("idle");

    // Cold release and a few RUN enable periods.
    run_release("cold", RunAt + 3 * Div);

    // Loss of lock in RUN, then relock.
    drop_in_run("loss1");
    run_release("relock1", RunAt + Div);

    // Dropout in HOLD at hold count 10 for three cycles.
    drop_in_run("loss2");
    bus.pll_locked = 1'b1;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      check_bit("hold.ce_main", bus.ce_main, 1'b0);
      check_bit("hold.core_rst", bus.core_rst, 1'b1);
    end
    bus.pll_locked = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_bit("dropout.ce_main", bus.ce_main, 1'b0);
      check_bit("dropout.ready", bus.ready, 1'b0);
    end
    run_release("after_dropout", RunAt + Div);

    // Many lock/unlock cycles: loss_cnt saturates at 255.
    for (int i = 0; i < 300; i++) begin
      drop_in_run("sat.drop");
      run_release("sat.relock", RunAt + 1);
    end
    check_loss("sat.final");

    // Async reset in mid-RUN, then restart with lock held high.
    rst = 1'b1;
    exp_loss = 0;
    #1;
    check_reset_values("rst_run");
    @(negedge clk);
    rst = 1'b0;
    run_release("after_rst_run", AlignAt + 3);

    // Async reset in mid-ALIGN, then restart.
    rst = 1'b1;
    #1;
    check_reset_values("rst_align");
    @(negedge clk);
    rst = 1'b0;
    run_release("after_rst_align", RunAt + 2 * Div);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
